// File: rtl/tdd_profile_seq_pkg.sv
// Shared types and helpers for the TDD profile sequencer.
//   seq_state_t        : sequencer FSM states
//   profile_idx_width  : width of a profile index for a given profile count
package tdd_profile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    SYNC,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  function automatic int unsigned profile_idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdd_profile_seq_burst_cnt.sv
// Per-profile frame counter for the TDD profile sequencer.
//   clk_i, resetn_i : clock, synchronous active-low reset
//   clear_i         : zero the count (profile load)
//   inc_i           : count one end-of-frame
//   limit_i         : frames in this profile, 0 = unlimited
//   done_o          : combinational; high when this increment reaches limit_i
module tdd_profile_seq_burst_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign cnt_d  = cnt_q + WIDTH'(1);
  assign done_o = inc_i && (limit_i != '0) && (cnt_d == limit_i);

  always_ff @(posedge clk_i) begin
    if (!resetn_i || clear_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdd_profile_seq.sv
// TDD profile sequencer: steps a TDD engine through up to PROFILE_COUNT
// stored frame profiles, each running for a configured number of frames.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   seq_start/seq_abort  : one-cycle start / abort requests
//   seq_loop             : restart from profile 0 after the last profile
//   seq_num              : number of profiles to run (1..PROFILE_COUNT)
//   cfg_frame_length     : packed frame lengths, profile 0 in LSBs
//   cfg_burst_count      : packed frames per profile (0 = run until abort)
//   tdd_endof_frame      : end-of-frame pulse from the TDD counter
//   tdd_enable, tdd_sync_soft, tdd_frame_length, tdd_burst_count : engine controls
//   seq_busy, seq_done, seq_profile, seq_frame_count : status
// Optional feature: define TDD_PROFILE_SEQ_FRAME_COUNT_EN to enable the
// saturating total frame counter on seq_frame_count (tied to 0 otherwise).
module tdd_profile_seq
  import tdd_profile_seq_pkg::*;
#(
  parameter int unsigned PROFILE_COUNT     = 4,
  parameter int unsigned REGISTER_WIDTH    = 32,
  parameter int unsigned BURST_COUNT_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   seq_start,
  input  logic                                   seq_abort,
  input  logic                                   seq_loop,
  input  logic [$clog2(PROFILE_COUNT):0]         seq_num,
  input  logic [PROFILE_COUNT*REGISTER_WIDTH-1:0]    cfg_frame_length,
  input  logic [PROFILE_COUNT*BURST_COUNT_WIDTH-1:0] cfg_burst_count,
  input  logic                                   tdd_endof_frame,
  output logic                                   tdd_enable,
  output logic                                   tdd_sync_soft,
  output logic [REGISTER_WIDTH-1:0]              tdd_frame_length,
  output logic [BURST_COUNT_WIDTH-1:0]           tdd_burst_count,
  output logic                                   seq_busy,
  output logic                                   seq_done,
  output logic [profile_idx_width(PROFILE_COUNT)-1:0] seq_profile,
  output logic [31:0]                            seq_frame_count
);

  localparam int unsigned PW  = $clog2(PROFILE_COUNT) + 1;
  localparam int unsigned PIW = profile_idx_width(PROFILE_COUNT);

  seq_state_t state_q, state_d;
  logic [PIW-1:0] prof_q, prof_d;
  logic           aborted_q, aborted_d;
  logic [REGISTER_WIDTH-1:0]    len_q;
  logic [BURST_COUNT_WIDTH-1:0] burst_q;

  logic start_ok;
  logic load_en;
  logic cnt_inc;
  logic cnt_done;

  always_comb begin
    state_d   = state_q;
    prof_d    = prof_q;
    aborted_d = aborted_q;
    start_ok  = 1'b0;
    load_en   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_start && (seq_num != '0) && (seq_num <= PW'(PROFILE_COUNT))) begin
          start_ok  = 1'b1;
          prof_d    = '0;
          aborted_d = 1'b0;
          state_d   = LOAD;
        end
      end
      default: begin
        // Abort outranks every per-state action, including a coincident
        // end-of-frame, so the aborted frame never counts.
        if (seq_abort) begin
          aborted_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          case (state_q)
            LOAD: begin
              load_en = 1'b1;
              state_d = ARM;
            end
            ARM:  state_d = SYNC;
            SYNC: state_d = RUN;
            RUN: begin
              if (tdd_endof_frame) begin
                cnt_inc = 1'b1;
                if (cnt_done) state_d = DRAIN;
              end
            end
            DRAIN: begin
              if (aborted_q) begin
                state_d = IDLE;
              end else if ((PW'(prof_q) + PW'(1)) < seq_num) begin
                prof_d  = prof_q + PIW'(1);
                state_d = LOAD;
              end else if (seq_loop) begin
                prof_d  = '0;
                state_d = LOAD;
              end else begin
                state_d = DONE;
              end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      prof_q    <= '0;
      aborted_q <= 1'b0;
      len_q     <= '0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      prof_q    <= prof_d;
      aborted_q <= aborted_d;
      if (load_en) begin
        len_q   <= cfg_frame_length[prof_q*REGISTER_WIDTH +: REGISTER_WIDTH];
        burst_q <= cfg_burst_count[prof_q*BURST_COUNT_WIDTH +: BURST_COUNT_WIDTH];
      end
    end
  end

  tdd_profile_seq_burst_cnt #(
    .WIDTH (BURST_COUNT_WIDTH)
  ) u_burst_cnt (
    .clk_i    (clk),
    .resetn_i (resetn),
    .clear_i  (load_en),
    .inc_i    (cnt_inc),
    .limit_i  (burst_q),
    .done_o   (cnt_done)
  );

`ifdef TDD_PROFILE_SEQ_FRAME_COUNT_EN
  logic [31:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (!resetn || start_ok) begin
      fcnt_q <= '0;
    end else if (cnt_inc && (fcnt_q != '1)) begin
      fcnt_q <= fcnt_q + 32'd1;
    end
  end

  assign seq_frame_count = fcnt_q;
`else
  assign seq_frame_count = '0;
`endif

  assign tdd_enable       = (state_q == ARM) || (state_q == SYNC) || (state_q == RUN);
  assign tdd_sync_soft    = (state_q == SYNC);
  assign seq_busy         = (state_q != IDLE);
  assign seq_done         = (state_q == DONE);
  assign seq_profile      = prof_q;
  assign tdd_frame_length = len_q;
  assign tdd_burst_count  = burst_q;

endmodule

// File: doc/tdd_profile_seq.md
TDD_PROFILE_SEQ -- requirements
Module: tdd_profile_seq

Interface
REQ-001 SHALL have parameter PROFILE_COUNT, default 4, number of stored frame profiles (2..16).
REQ-002 SHALL have parameter REGISTER_WIDTH, default 32, frame-length width.
REQ-003 SHALL have parameter BURST_COUNT_WIDTH, default 32, per-profile frame-count width.
REQ-004 SHALL use one clock; reset is synchronous and active-low: clk  in  1  block clock; resetn  in  1  sync active-low reset.
REQ-005 SHALL have seq_start  in  1  one-cycle start request.
REQ-006 SHALL have seq_abort  in  1  one-cycle abort request.
REQ-007 SHALL have seq_loop  in  1  level; restart from profile 0 after last profile.
REQ-008 SHALL have seq_num  in  PW=$clog2(PROFILE_COUNT)+1  number of profiles to run.
REQ-009 SHALL have cfg_frame_length  in  PROFILE_COUNT*REGISTER_WIDTH  packed frame lengths, profile 0 in LSBs.
REQ-010 SHALL have cfg_burst_count  in  PROFILE_COUNT*BURST_COUNT_WIDTH  packed frames per profile, profile 0 in LSBs.
REQ-011 SHALL have tdd_endof_frame  in  1  one-cycle end-of-frame pulse from the TDD counter.
REQ-012 SHALL have outputs tdd_enable 1, tdd_sync_soft 1, tdd_frame_length REGISTER_WIDTH, tdd_burst_count BURST_COUNT_WIDTH driving the TDD engine.
REQ-013 SHALL have outputs seq_busy 1, seq_done 1 (pulse), seq_profile $clog2(PROFILE_COUNT) current index, seq_frame_count 32.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, ARM, SYNC, RUN, DRAIN, DONE.
REQ-015 SHALL, in IDLE on seq_start with 1<=seq_num<=PROFILE_COUNT, set index 0 and enter LOAD; seq_start with other seq_num SHALL be ignored.
REQ-016 SHALL, in LOAD (1 cycle), register tdd_frame_length/tdd_burst_count from the indexed profile and clear the frame counter; next ARM.
REQ-017 SHALL, in ARM (1 cycle), assert tdd_enable; next SYNC.
REQ-018 SHALL, in SYNC, pulse tdd_sync_soft for exactly one cycle; next RUN; seq_start to tdd_sync_soft latency = 3 cycles.
REQ-019 SHALL, in RUN, count tdd_endof_frame pulses; on count reaching cfg burst count go to DRAIN; burst count 0 SHALL run until abort.
REQ-020 SHALL, in DRAIN (1 cycle), deassert tdd_enable; then if index+1<seq_num, increment index -> LOAD; else if seq_loop, index 0 -> LOAD; else DONE.
REQ-021 SHALL, in DONE, pulse seq_done one cycle and return to IDLE.
REQ-022 SHALL hold tdd_enable high in ARM, SYNC, RUN only; seq_busy high in every state except IDLE.
REQ-023 SHALL on seq_abort in any non-IDLE state go to DRAIN next cycle then IDLE without seq_done; abort has priority over simultaneous tdd_endof_frame.
REQ-024 SHALL ignore seq_start while busy and seq_abort while IDLE.
REQ-025 SHALL ignore tdd_endof_frame outside RUN.
REQ-026 SHALL sample seq_num and seq_loop at DRAIN decision time; profile config sampled only in LOAD.

Reset
REQ-027 SHALL on resetn low at a clk edge enter IDLE; tdd_enable, tdd_sync_soft, seq_busy, seq_done 0; tdd_frame_length, tdd_burst_count, seq_profile, seq_frame_count 0.
REQ-028 SHALL apply reset mid-sequence identically, deasserting tdd_enable on the next edge.

Configuration
REQ-029 SHALL, with TDD_PROFILE_SEQ_FRAME_COUNT_EN defined, increment seq_frame_count on each RUN-state tdd_endof_frame, saturating at 2^32-1, cleared on start only.
REQ-030 SHALL, without TDD_PROFILE_SEQ_FRAME_COUNT_EN, tie seq_frame_count to 0 and infer no counter.

Structure
REQ-031 SHALL place seq_state_t enum and profile-index width function in package tdd_profile_seq_pkg.
REQ-032 SHALL implement per-profile frame counting in one sub-module tdd_profile_seq_burst_cnt (clear, inc, limit, done).

Verification
REQ-033 SHALL cover: seq_num=2, bursts {3,2}, lengths {100,200} -> tdd_enable drops after 3 frames, reloads length 200, seq_done after 5 total frames.
REQ-034 SHALL cover: seq_loop=1, seq_num=2, bursts {1,1} -> profile index 0,1,0,1 across four frames, no seq_done.
REQ-035 SHALL cover: burst 0, abort after 10 frames -> DRAIN then IDLE, no seq_done, seq_frame_count=10 with macro.
REQ-036 SHALL cover: seq_abort and tdd_endof_frame same cycle in RUN -> abort wins, frame not counted toward profile switch.
REQ-037 SHALL cover: resetn low during RUN -> all outputs 0 next cycle; seq_start with seq_num=0 -> stays IDLE.
